montgomery_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `montgomery` multiplier instance between N requesters, such as several exponentiation engines or a pre-computation unit. It sits between the requesters and the multiplier. For each granted request it latches that requester's operands and applies a one-cycle clear to the multiplier. It then pulses the multiplier's start, waits for its done, and returns the registered product with a one-cycle done pulse to the owning requester.

---
 rtl/montgomery_arbiter.sv | 133 +++++++++++++
 tb/tb_montgomery_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_arbiter.sv
// Round-robin arbiter/sequencer sharing one montgomery multiplier among N requesters.
// Ports:
//   clk, resetn        clock and async active-low reset
//   req[N]             level request per requester, held until its done
//   in_a/in_b[N*W]     per-requester operands, requester i at [i*W +: W]
//   in_m[W]            shared modulus, stable while busy
//   gnt[N]             one-hot owner of the multiplier (0 when idle)
//   done[N]            one-cycle pulse to the owner when result is valid
//   result[W]          captured product, held until the next capture
//   busy               high whenever the sequencer is not idle
//   mont_*             multiplier-side controls, operands and handshake
module montgomery_arbiter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   in_a,
  input  logic [N*W-1:0]   in_b,
  input  logic [W-1:0]     in_m,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic             mont_resetn,
  output logic             mont_start,
  output logic [W-1:0]     mont_a,
  output logic [W-1:0]     mont_b,
  output logic [W-1:0]     mont_m,
  input  logic [W-1:0]     mont_result,
  input  logic             mont_done
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_ptr;
  logic          win_found;
  int unsigned   idx;

  // Multiplier is held in reset during CLEAR; modulus passes straight through.
  assign mont_resetn = resetn & (state != S_CLEAR);
  assign mont_m      = in_m;

  // Pointer after the current owner, wrapping at N.
  assign next_ptr = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);

  // First requester at or above ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  // Sequencer: grant, clear, start, wait, deliver.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      gnt        <= '0;
      done       <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            mont_a <= in_a[32'(win_idx) * W +: W];
            mont_b <= in_b[32'(win_idx) * W +: W];
            gnt    <= N'(1) << win_idx;
            owner  <= win_idx;
            busy   <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          mont_start <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          mont_start <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (mont_done) begin
            result <= mont_result;
            done   <= gnt;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= next_ptr;
          state <= S_IDLE;
        end
        default: begin
          done       <= '0;
          gnt        <= '0;
          busy       <= 1'b0;
          mont_start <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_arbiter.sv
// Self-checking bench for montgomery_arbiter with a mock multiplier
// (a*b mod m after a programmable latency) and a cycle-level reference model.
module tb_montgomery_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   in_a = '0;
  logic [N*W-1:0]   in_b = '0;
  logic [W-1:0]     in_m = 16'd13;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [W-1:0]     result;
  logic             busy;
  logic             mont_resetn;
  logic             mont_start;
  logic [W-1:0]     mont_a;
  logic [W-1:0]     mont_b;
  logic [W-1:0]     mont_m;
  logic [W-1:0]     mont_result = '0;
  logic             mont_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  montgomery_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .resetn(resetn), .req(req), .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .mont_resetn(mont_resetn), .mont_start(mont_start),
    .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mock multiplier: done pulses lat cycles after start; spurious dones when idle.
  int          lat = 10;
  bit          spur_en = 1'b0;
  int          mcnt = 0;
  logic [W-1:0] mprod = '0;
  always @(posedge clk) begin
    if (!mont_resetn) begin
      mcnt        <= 0;
      mont_done   <= 1'b0;
      mont_result <= '0;
    end else if (mont_start) begin
      mcnt      <= lat;
      mprod     <= W'((longint'(mont_a) * longint'(mont_b)) % longint'(mont_m));
      mont_done <= 1'b0;
    end else if (mcnt > 0) begin
      mcnt      <= mcnt - 1;
      mont_done <= (mcnt == 1);
      if (mcnt == 1) mont_result <= mprod;
    end else begin
      mont_done   <= spur_en && ($urandom_range(0, 3) == 0);
      mont_result <= W'($urandom);
    end
  end

  // Reference model: owner + cycles since grant; product computed from the
  // operands the owner presented at grant time.
  bit           m_busy = 1'b0;
  bit           m_fin = 1'b0;
  int           m_since = 0;
  int           m_owner = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_mod = '0, m_result = '0;

  task automatic model_reset();
    m_busy = 1'b0; m_fin = 1'b0; m_since = 0; m_owner = 0; m_ptr = 0;
    m_a = '0; m_b = '0; m_result = '0;
  endtask

  task automatic model_step();
    bit f;
    if (m_fin) begin
      m_fin = 1'b0; m_busy = 1'b0; m_since = 0;
      m_ptr = (m_owner + 1) % N;
    end else if (m_busy) begin
      if (m_since < 3) m_since++;
      else if (mont_done) begin
        m_result = W'((longint'(m_a) * longint'(m_b)) % longint'(m_mod));
        m_fin = 1'b1;
      end
    end else if (req != '0) begin
      f = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (!f && req[i]) begin f = 1'b1; m_owner = i; end
      end
      m_a = in_a[m_owner*W +: W];
      m_b = in_b[m_owner*W +: W];
      m_mod = in_m;
      m_busy = 1'b1;
      m_since = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    logic [N-1:0] eg, ed;
    @(posedge clk);
    #1;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    ed = m_fin ? (N'(1) << m_owner) : '0;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("done", 64'(done), 64'(ed));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("result", 64'(result), 64'(m_result));
    chk("mont_start", 64'(mont_start), 64'(m_busy && m_since == 2));
    chk("mont_resetn", 64'(mont_resetn), 64'(resetn && !(m_busy && m_since == 1)));
    chk("mont_a", 64'(mont_a), 64'(m_a));
    chk("mont_b", 64'(mont_b), 64'(m_b));
    chk("mont_m", 64'(mont_m), 64'(in_m));
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start(input string nm);
    int c = 0;
    while (!mont_start && c < 20) begin @(negedge clk); c++; end
    chk(nm, 64'(mont_start), 64'(1));
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk(nm, 64'(done != '0), 64'(1));
  endtask

  initial begin
    int cyc, k, n, nd, ng;
    bit seen;
    logic [N-1:0] exp_o [3];
    logic [W-1:0] exp_r [3];

    // Reset defaults
    @(negedge clk);
    chk("rst_mont_resetn_low", 64'(mont_resetn), 64'(0));
    chk("rst_gnt", 64'(gnt), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mont_resetn_high", 64'(mont_resetn), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_mont_start", 64'(mont_start), 64'(0));

    // Single request: 5*7 mod 13 = 9, L = 10
    lat = 10; in_m = 16'd13;
    in_a[0*W +: W] = 16'd5; in_b[0*W +: W] = 16'd7;
    req = 2'b01;
    @(negedge clk);
    chk("t2_gnt_c1", 64'(gnt), 64'(2'b01));
    chk("t2_busy_c1", 64'(busy), 64'(1));
    chk("t2_clear_c1", 64'(mont_resetn), 64'(0));
    @(negedge clk);
    chk("t2_start_c2", 64'(mont_start), 64'(1));
    chk("t2_mrst_c2", 64'(mont_resetn), 64'(1));
    @(negedge clk);
    chk("t2_start_c3", 64'(mont_start), 64'(0));
    wait_done("t2_done_seen", cyc);
    chk("t2_latency", 64'(3 + cyc), 64'(14));
    chk("t2_result", 64'(result), 64'(9));
    chk("t2_done_owner", 64'(done), 64'(2'b01));
    req = '0;
    @(negedge clk);
    chk("t2_busy_after", 64'(busy), 64'(0));
    chk("t2_done_once", 64'(done), 64'(0));
    @(negedge clk);
    chk("t2_no_regrant", 64'(gnt), 64'(0));

    // Contention: grants alternate 01,10,01 with own products
    do_reset();
    lat = 3;
    in_a[0*W +: W] = 16'd3; in_b[0*W +: W] = 16'd4;
    in_a[1*W +: W] = 16'd6; in_b[1*W +: W] = 16'd9;
    exp_o[0] = 2'b01; exp_o[1] = 2'b10; exp_o[2] = 2'b01;
    exp_r[0] = 16'd12; exp_r[1] = 16'd2; exp_r[2] = 16'd12;
    req = 2'b11;
    k = 0; n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk); n++;
      if (done != '0) begin
        chk("t3_owner", 64'(done), 64'(exp_o[k]));
        chk("t3_result", 64'(result), 64'(exp_r[k]));
        k++;
        if (k == 3) req = '0;
      end
    end
    chk("t3_ops", 64'(k), 64'(3));
    repeat (2) @(negedge clk);

    // Operand change during WAIT has no effect
    in_a[0*W +: W] = 16'd5; in_b[0*W +: W] = 16'd7;
    req = 2'b01;
    wait_start("t4_start");
    repeat (2) @(negedge clk);
    in_a[0*W +: W] = 16'd11; in_b[0*W +: W] = 16'd2;
    wait_done("t4_done_seen", cyc);
    chk("t4_result_latched", 64'(result), 64'(9));
    req = '0;
    repeat (2) @(negedge clk);

    // Request drop mid-WAIT still completes exactly once
    in_a[1*W +: W] = 16'd2; in_b[1*W +: W] = 16'd3;
    req = 2'b10;
    wait_start("t5_start");
    @(negedge clk);
    req = '0;
    nd = 0; ng = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done[1]) begin
        nd++; seen = 1'b1;
        chk("t5_result", 64'(result), 64'(6));
      end else if (seen && gnt != '0) ng++;
    end
    chk("t5_done_pulses", 64'(nd), 64'(1));
    chk("t5_no_regrant", 64'(ng), 64'(0));

    // Reset mid-operation
    lat = 10;
    in_a[0*W +: W] = 16'd5; in_b[0*W +: W] = 16'd7;
    req = 2'b01;
    wait_start("t6_start");
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    req = 2'b10;
    #1;
    chk("t6_gnt0", 64'(gnt), 64'(0));
    chk("t6_busy0", 64'(busy), 64'(0));
    chk("t6_result0", 64'(result), 64'(0));
    chk("t6_mont_a0", 64'(mont_a), 64'(0));
    chk("t6_mont_resetn0", 64'(mont_resetn), 64'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_gnt_to_1", 64'(gnt), 64'(2'b10));
    wait_done("t6_done_seen", cyc);
    req = '0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model
    do_reset();
    spur_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!busy) begin
        lat = $urandom_range(1, 8);
        in_m = W'($urandom_range(3, 65535)) | W'(1);
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 1) == 1) in_a[i*W +: W] = W'($urandom);
        if ($urandom_range(0, 1) == 1) in_b[i*W +: W] = W'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
    end
    req = '0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
